// File: rtl/wav_pkg.sv
// Shared types and default sizing for the wav playback path.
package wav_pkg;
   localparam int WAV_DATA_WIDTH = 16;
   localparam int WAV_NUM_CH     = 2;
   localparam int WAV_MEM_DEPTH  = 44000;
   localparam int WAV_RD_LATENCY = 1;

   typedef enum logic [1:0] {IDLE, FETCH, READY} play_state_t;
   typedef logic signed [WAV_DATA_WIDTH-1:0] sample_t;
endpackage

// File: rtl/bram_frame_fetch.sv
// Issues NUM_CH consecutive BRAM reads from a base address and assembles the returned words
// into a frame shadow; frame_rdy marks the cycle the last channel lands.
module bram_frame_fetch
   import wav_pkg::*;
#(
   parameter int DATA_WIDTH = WAV_DATA_WIDTH,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_CH     = WAV_NUM_CH,
   parameter int RD_LATENCY = WAV_RD_LATENCY
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         go,
   input  logic                         flush,
   input  logic [ADDR_WIDTH-1:0]        base_addr,
   input  logic [DATA_WIDTH-1:0]        mem_dout,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [NUM_CH*DATA_WIDTH-1:0] frame,
   output logic                         frame_rdy
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(NUM_CH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CH);

   logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [RD_LATENCY-1:0]              vld_q, vld_d;
   logic [RD_LATENCY-1:0][CH_W-1:0]    ch_q, ch_d;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d;
   logic                               iss_vld;
   logic [CH_W-1:0]                    iss_ch;

   always_comb begin
      iss_vld = (cnt_q != '0);
      iss_ch  = CH_W'(CNT_FULL - cnt_q);
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      if (go) begin
         addr_d = base_addr;
         cnt_d  = CNT_FULL;
      end else if (flush) begin
         cnt_d = '0;
      end else if (iss_vld) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q > CNT_W'(1)) addr_d = addr_q + ADDR_WIDTH'(1);
      end

      // Read tags travel alongside the BRAM latency so each word lands in its channel slot.
      vld_d[0] = iss_vld;
      ch_d[0]  = iss_ch;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         ch_d[i]  = ch_q[i-1];
      end
      if (flush) vld_d = '0;

      shadow_d = shadow_q;
      if (vld_q[RD_LATENCY-1]) shadow_d[ch_q[RD_LATENCY-1]] = mem_dout;
      frame_rdy = vld_q[RD_LATENCY-1] && (ch_q[RD_LATENCY-1] == CH_W'(NUM_CH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         cnt_q    <= '0;
         vld_q    <= '0;
         ch_q     <= '0;
         shadow_q <= '0;
      end else begin
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         ch_q     <= ch_d;
         shadow_q <= shadow_d;
      end
   end

   assign mem_addr = addr_q;
   assign frame    = shadow_q;
endmodule

// File: rtl/wav_playback_ctrl.sv
// Region-addressed multi-channel sample player: one frame per sample tick from the wav BRAM.
// IDLE: stopped | FETCH: reading next frame into shadow | READY: frame waiting for a tick
module wav_playback_ctrl
   import wav_pkg::*;
#(
   parameter int DATA_WIDTH = WAV_DATA_WIDTH,
   parameter int MEM_DEPTH  = WAV_MEM_DEPTH,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int NUM_CH     = WAV_NUM_CH,
   parameter int RD_LATENCY = WAV_RD_LATENCY
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop_en,
   input  logic [ADDR_WIDTH-1:0]        start_addr,
   input  logic [ADDR_WIDTH-1:0]        end_addr,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_dout,
   output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
   output logic                         valid_out,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         underrun
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] CH_STEP   = PW'(NUM_CH);
   localparam logic [PW-1:0] LAST_WORD = PW'(MEM_DEPTH - 1);

   play_state_t                  state_q, state_d;
   logic [PW-1:0]                ptr_q, ptr_d, start_q, start_d, end_q, end_d;
   logic                         loop_q, loop_d, busy_q, busy_d;
   logic [NUM_CH*DATA_WIDTH-1:0] data_q, data_d, shadow;
   logic                         valid_q, valid_d, done_q, done_d, err_q, err_d, und_q, und_d;
   logic                         go, flush, frame_rdy, req_ok, at_last;
   logic [PW-1:0]                req_start, req_end, req_len;
   logic [ADDR_WIDTH-1:0]        fetch_base;

   always_comb begin
      req_start = {1'b0, start_addr};
      req_end   = {1'b0, end_addr};
      req_len   = req_end - req_start + PW'(1);
      req_ok    = (req_start <= req_end) && (req_end <= LAST_WORD) && ((req_len % CH_STEP) == '0);
      at_last   = ((ptr_q + CH_STEP - PW'(1)) == end_q);

      state_d    = state_q;
      ptr_d      = ptr_q;
      start_d    = start_q;
      end_d      = end_q;
      loop_d     = loop_q;
      busy_d     = busy_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      und_d      = 1'b0;
      go         = 1'b0;
      flush      = 1'b0;
      fetch_base = ptr_q[ADDR_WIDTH-1:0];

      if (stop) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         flush   = 1'b1;
      end else if (start && req_ok) begin
         state_d    = FETCH;
         busy_d     = 1'b1;
         flush      = 1'b1;
         go         = 1'b1;
         ptr_d      = req_start;
         start_d    = req_start;
         end_d      = req_end;
         loop_d     = loop_en;
         fetch_base = start_addr;
      end else begin
         // A rejected start leaves the player alone, so the tick is still serviced.
         err_d = start;
         case (state_q)
            FETCH: begin
               if (frame_rdy) state_d = READY;
               if (enable) und_d = 1'b1;
            end
            READY: begin
               if (enable) begin
                  data_d  = shadow;
                  valid_d = 1'b1;
                  if (at_last && !loop_q) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     ptr_d      = at_last ? start_q : ptr_q + CH_STEP;
                     go         = 1'b1;
                     fetch_base = ptr_d[ADDR_WIDTH-1:0];
                     state_d    = FETCH;
                  end
               end
            end
            default: begin
               if (enable && busy_q) und_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         start_q <= '0;
         end_q   <= '0;
         loop_q  <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         start_q <= start_d;
         end_q   <= end_d;
         loop_q  <= loop_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
         und_q   <= und_d;
      end
   end

   bram_frame_fetch #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_CH     (NUM_CH),
      .RD_LATENCY (RD_LATENCY)
   ) u_fetch (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .flush     (flush),
      .base_addr (fetch_base),
      .mem_dout  (mem_dout),
      .mem_addr  (mem_addr),
      .frame     (shadow),
      .frame_rdy (frame_rdy)
   );

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign underrun  = und_q;
endmodule

// File: tb/tb_wav_playback_ctrl.sv
// Bench for wav_playback_ctrl: two instances (BRAM latency 1 and 3) against a timestamp-based player model.
module tb_wav_playback_ctrl;
   import wav_pkg::*;

   localparam int DW  = 16;
   localparam int MD  = 44000;
   localparam int AW  = 16;
   localparam int NCH = 2;
   localparam int FW  = NCH * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, enable, start, stop, loop_en;
   logic [AW-1:0] start_addr, end_addr;
   logic [AW-1:0] mem_addr [2];
   logic [DW-1:0] mem_dout [2];
   logic [FW-1:0] data_out [2];
   logic          valid_out [2], busy [2], done [2], err [2], underrun [2];

   wav_playback_ctrl #(.RD_LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .loop_en(loop_en),
      .start_addr(start_addr), .end_addr(end_addr), .mem_addr(mem_addr[0]), .mem_dout(mem_dout[0]),
      .data_out(data_out[0]), .valid_out(valid_out[0]), .busy(busy[0]), .done(done[0]),
      .err(err[0]), .underrun(underrun[0])
   );

   wav_playback_ctrl #(.RD_LATENCY(3)) u_dut_l3 (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .loop_en(loop_en),
      .start_addr(start_addr), .end_addr(end_addr), .mem_addr(mem_addr[1]), .mem_dout(mem_dout[1]),
      .data_out(data_out[1]), .valid_out(valid_out[1]), .busy(busy[1]), .done(done[1]),
      .err(err[1]), .underrun(underrun[1])
   );

   // BRAM content is mem[i] = i.
   function automatic sample_t mem_word(input int a);
      return sample_t'(a[DW-1:0]);
   endfunction

   logic [AW-1:0] rd_p0;
   logic [AW-1:0] rd_p1 [3];
   always @(posedge clk) begin
      rd_p0    <= mem_addr[0];
      rd_p1[0] <= mem_addr[1];
      rd_p1[1] <= rd_p1[0];
      rd_p1[2] <= rd_p1[1];
   end
   assign mem_dout[0] = mem_word(int'(rd_p0));
   assign mem_dout[1] = mem_word(int'(rd_p1[2]));

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: a frame becomes presentable NCH+LAT+1 cycles after its fetch is kicked off.
   int            lat [2] = '{1, 3};
   int            cyc = 0;
   bit            m_play [2];
   bit            m_loop [2];
   int            m_ptr [2], m_rs [2], m_re [2], m_rdy [2], m_iss [2], e_addr [2];
   logic [FW-1:0] e_data [2];
   bit            e_valid [2], e_done [2], e_err [2], e_und [2];

   function automatic bit region_ok(input int sa, input int ea);
      return (sa <= ea) && (ea <= MD - 1) && (((ea - sa + 1) % NCH) == 0);
   endfunction

   function automatic logic [FW-1:0] frame_at(input int p);
      logic [FW-1:0] f;
      for (int c = 0; c < NCH; c++) f[c*DW +: DW] = mem_word(p + c);
      return f;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit kick;
         int base;
         kick = 1'b0;
         base = 0;
         e_valid[d] = 1'b0;
         e_done[d]  = 1'b0;
         e_err[d]   = 1'b0;
         e_und[d]   = 1'b0;
         if (rst) begin
            m_play[d] = 1'b0;
            e_data[d] = '0;
            e_addr[d] = 0;
            m_iss[d]  = 0;
         end else if (stop) begin
            m_play[d] = 1'b0;
            m_iss[d]  = 0;
         end else if (start && region_ok(int'(start_addr), int'(end_addr))) begin
            m_play[d] = 1'b1;
            m_rs[d]   = int'(start_addr);
            m_re[d]   = int'(end_addr);
            m_loop[d] = loop_en;
            m_ptr[d]  = int'(start_addr);
            kick      = 1'b1;
            base      = m_ptr[d];
         end else begin
            e_err[d] = start;
            if (m_play[d] && enable) begin
               if (cyc >= m_rdy[d]) begin
                  e_data[d]  = frame_at(m_ptr[d]);
                  e_valid[d] = 1'b1;
                  if (m_ptr[d] + NCH - 1 == m_re[d]) begin
                     if (m_loop[d]) begin
                        m_ptr[d] = m_rs[d];
                        kick     = 1'b1;
                     end else begin
                        e_done[d] = 1'b1;
                        m_play[d] = 1'b0;
                     end
                  end else begin
                     m_ptr[d] = m_ptr[d] + NCH;
                     kick     = 1'b1;
                  end
                  base = m_ptr[d];
               end else begin
                  e_und[d] = 1'b1;
               end
            end
            if (!kick && m_iss[d] > 0) begin
               e_addr[d]++;
               m_iss[d]--;
            end
         end
         if (kick) begin
            e_addr[d] = base;
            m_iss[d]  = NCH - 1;
            m_rdy[d]  = cyc + 1 + NCH + lat[d];
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check_val($sformatf("dut%0d busy", d),     64'(busy[d]),      64'(e_valid[d] ? m_play[d] : m_play[d]));
            check_val($sformatf("dut%0d valid", d),    64'(valid_out[d]), 64'(e_valid[d]));
            check_val($sformatf("dut%0d done", d),     64'(done[d]),      64'(e_done[d]));
            check_val($sformatf("dut%0d err", d),      64'(err[d]),       64'(e_err[d]));
            check_val($sformatf("dut%0d underrun", d), 64'(underrun[d]),  64'(e_und[d]));
            check_val($sformatf("dut%0d data", d),     64'(data_out[d]),  64'(e_data[d]));
            check_val($sformatf("dut%0d mem_addr", d), 64'(mem_addr[d]),  64'(e_addr[d]));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int sa, input int ea, input bit lp);
      @(negedge clk);
      start      = 1'b1;
      start_addr = AW'(sa);
      end_addr   = AW'(ea);
      loop_en    = lp;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("dut%0d rst data", d), 64'(data_out[d]), 64'd0);
         check_val($sformatf("dut%0d rst addr", d), 64'(mem_addr[d]), 64'd0);
         check_val($sformatf("dut%0d rst busy", d), 64'(busy[d]),     64'd0);
      end
   endtask

   // Pulses one tick; on return the registered response to it is visible.
   task automatic tick_expect(input logic [FW-1:0] exp, input bit want);
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("dut%0d tick valid", d), 64'(valid_out[d]), 64'(want));
         if (want) check_val($sformatf("dut%0d frame", d), 64'(data_out[d]), 64'(exp));
      end
   endtask

   localparam logic [FW-1:0] FR_10  = {16'd11, 16'd10};
   localparam logic [FW-1:0] FR_12  = {16'd13, 16'd12};
   localparam logic [FW-1:0] FR_14  = {16'd15, 16'd14};
   localparam logic [FW-1:0] FR_16  = {16'd17, 16'd16};
   localparam logic [FW-1:0] FR_100 = {16'd101, 16'd100};

   initial begin
      rst = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      start_addr = '0; end_addr = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst    = 1'b0;

      // One-shot 10..17
      do_start(10, 17, 1'b0);
      wait_cyc(100); tick_expect(FR_10, 1'b1);
      wait_cyc(100); tick_expect(FR_12, 1'b1);
      wait_cyc(100); tick_expect(FR_14, 1'b1);
      wait_cyc(100); tick_expect(FR_16, 1'b1);
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d done last", d), 64'(done[d]), 64'd1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d busy after done", d), 64'(busy[d]), 64'd0);
      wait_cyc(100); tick_expect('0, 1'b0);

      // Looping 10..17, then stop holds the last frame
      do_start(10, 17, 1'b1);
      wait_cyc(30); tick_expect(FR_10, 1'b1);
      wait_cyc(30); tick_expect(FR_12, 1'b1);
      wait_cyc(30); tick_expect(FR_14, 1'b1);
      wait_cyc(30); tick_expect(FR_16, 1'b1);
      wait_cyc(30); tick_expect(FR_10, 1'b1);
      wait_cyc(30); tick_expect(FR_12, 1'b1);
      do_stop();
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("dut%0d busy after stop", d), 64'(busy[d]), 64'd0);
         check_val($sformatf("dut%0d data held", d), 64'(data_out[d]), 64'(FR_12));
      end

      // Rejected regions
      do_start(10, 16, 1'b0);
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d err odd", d), 64'(err[d]), 64'd1);
      do_start(20, 19, 1'b0);
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d err reversed", d), 64'(err[d]), 64'd1);
      do_start(43998, 44001, 1'b0);
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d err past end", d), 64'(err[d]), 64'd1);

      // Tick arriving mid-fetch
      do_start(10, 17, 1'b0);
      tick_expect('0, 1'b0);
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d early underrun", d), 64'(underrun[d]), 64'd1);
      wait_cyc(20); tick_expect(FR_10, 1'b1);
      do_stop();

      // Restart mid-fetch, then stop+start together
      do_start(10, 17, 1'b1);
      wait_cyc(20); tick_expect(FR_10, 1'b1);
      do_start(100, 103, 1'b0);
      wait_cyc(20); tick_expect(FR_100, 1'b1);
      @(negedge clk);
      start = 1'b1; stop = 1'b1; start_addr = 16'd10; end_addr = 16'd17;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int d = 0; d < 2; d++) check_val($sformatf("dut%0d stop wins", d), 64'(busy[d]), 64'd0);
      wait_cyc(20); tick_expect('0, 1'b0);

      // Reset during FETCH and during READY
      do_start(10, 17, 1'b0);
      do_rst();
      do_start(10, 17, 1'b0);
      wait_cyc(20);
      do_rst();
      do_start(42000, 43999, 1'b0);
      wait_cyc(20); tick_expect({16'd42001, 16'd42000}, 1'b1);
      do_stop();

      // Randomised traffic
      repeat (4000) begin
         @(negedge clk);
         enable = ($urandom_range(0, 7) == 0);
         stop   = ($urandom_range(0, 299) == 0);
         rst    = ($urandom_range(0, 799) == 0);
         start  = 1'b0;
         if ($urandom_range(0, 39) == 0) begin
            int sa, len, ea;
            sa  = int'($urandom_range(0, MD - 1));
            len = int'($urandom_range(0, 9));
            ea  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MD, 65535)) : sa + len - 1;
            start      = 1'b1;
            loop_en    = $urandom_range(0, 1) == 1;
            start_addr = AW'(sa);
            end_addr   = AW'(ea < 0 ? 65535 : (ea > 65535 ? 65535 : ea));
         end
      end
      @(negedge clk);
      enable = 1'b0; start = 1'b0; stop = 1'b0; rst = 1'b0;
      wait_cyc(10);
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
